// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch queue slice.
//   DEPTH_DEFAULT : default number of in-order fetch entries
//   XLEN          : width of PCs and instruction words
//   fetch_entry_t : one queue entry (fetch PC, returned word, filled flag)
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int DEPTH_DEFAULT = 2;
    localparam int XLEN          = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ring.sv
// ---------------------------------------------------------------------------
// fetch_ring
// Entry storage for the fetch queue: a circular buffer of DEPTH entries with
// head/tail pointers and an occupancy count. Requests are allocated at the
// tail, responses fill the oldest unfilled entry, decode drains the head.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   clear_i        : flush every entry (redirect)
//   enq_i/enqPc_i  : allocate the tail entry for a fetch of enqPc_i
//   fill_i/fillData_i : write a returned word into the oldest unfilled entry
//   deq_i          : free the head entry
//   count_o        : number of allocated entries (0..DEPTH)
//   unfilled_o     : number of allocated entries still waiting for data
//   head_o         : the head entry as stored
// ---------------------------------------------------------------------------
module fetch_ring
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     enq_i,
    input  logic [XLEN-1:0]          enqPc_i,
    input  logic                     fill_i,
    input  logic [XLEN-1:0]          fillData_i,
    input  logic                     deq_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   unfilled_o,
    output fetch_entry_t             head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t       entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   fillIdx;
    logic [PTR_W-1:0]   scanIdx;
    logic               canFill;
    logic [CNT_W-1:0]   unfilled;

    // Walk the allocated region from the head. Because responses come back in
    // request order, the filled entries always form a prefix of that region,
    // so the first unfilled entry found is where the next response belongs.
    // The same walk also counts the entries whose requests are still in flight.
    always_comb begin
        unfilled = '0;
        fillIdx  = head_q;
        scanIdx  = head_q;
        canFill  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            scanIdx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && !entries_q[scanIdx].filled) begin
                unfilled = unfilled + CNT_W'(1);
                if (!canFill) begin
                    canFill = 1'b1;
                    fillIdx = scanIdx;
                end
            end
        end
    end

    // Pointer and occupancy next state. The top never enqueues into a full
    // ring and never dequeues an empty one, so no saturation is needed here.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        if (enq_i) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (deq_i) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq_i) - CNT_W'(deq_i);
    end

    // Storage and pointer registers. Reset and flush share one path: both
    // empty the ring and mark every entry unfilled. Allocation, fill and
    // dequeue never touch the same slot in one cycle, so their writes are
    // independent.
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].filled <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_i) begin
                entries_q[tail_q].pc     <= enqPc_i;
                entries_q[tail_q].filled <= 1'b0;
            end
            if (fill_i && canFill) begin
                entries_q[fillIdx].data   <= fillData_i;
                entries_q[fillIdx].filled <= 1'b1;
            end
            if (deq_i) begin
                entries_q[head_q].filled <= 1'b0;
            end
        end
    end

    assign count_o    = count_q;
    assign unfilled_o = unfilled;
    assign head_o     = entries_q[head_q];

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// In-order instruction fetch queue between the PC register, instruction
// memory and decode. Issues one fetch per free entry, stalls the PC when a
// fetch is not accepted, and discards responses that belong to fetches made
// before a redirect.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   io_pc                 : current fetch PC
//   io_redirect           : PC register is loading a new PC this cycle
//   io_stall              : hold the PC register
//   io_imem_req_*         : memory request channel (valid/ready/addr)
//   io_imem_resp_*        : memory response channel (valid/data, in order)
//   io_inst_*             : decode channel (valid/ready/data/pc)
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] io_pc,
    input  logic            io_redirect,
    output logic            io_stall,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    input  logic            io_imem_resp_valid,
    input  logic [XLEN-1:0] io_imem_resp_data,
    output logic            io_inst_valid,
    input  logic            io_inst_ready,
    output logic [XLEN-1:0] io_inst_data,
    output logic [XLEN-1:0] io_inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] unfilled;
    fetch_entry_t     headEntry;
    logic             accept;
    logic             dequeue;
    logic             fill;

    // Handshake decode. No new fetch goes out while stale responses are still
    // owed, so a discarded response can never be confused with a live one.
    always_comb begin
        io_imem_req_valid = !reset && (count < CNT_W'(DEPTH)) && (dropCnt_q == '0);
        io_imem_req_addr  = io_pc;
        accept            = io_imem_req_valid && io_imem_req_ready;
        io_stall          = !accept;
        io_inst_valid     = !reset && (count != '0) && headEntry.filled;
        io_inst_data      = headEntry.data;
        io_inst_pc        = headEntry.pc;
        dequeue           = io_inst_valid && io_inst_ready;
        fill              = io_imem_resp_valid && (dropCnt_q == '0) && !io_redirect;
    end

    // Outstanding stale responses. On a redirect every fetch still in flight
    // becomes stale: the ones already owed, the unfilled entries being thrown
    // away, and a request accepted in this same cycle. A response arriving in
    // the redirect cycle pays off one of those immediately.
    always_comb begin
        dropCnt_d = dropCnt_q;
        if (io_redirect) begin
            dropCnt_d = dropCnt_q + unfilled + CNT_W'(accept) - CNT_W'(io_imem_resp_valid);
        end else if (io_imem_resp_valid && (dropCnt_q != '0)) begin
            dropCnt_d = dropCnt_q - CNT_W'(1);
        end
    end

    // Stale-response counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            dropCnt_q <= '0;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end

    fetch_ring #(
        .DEPTH (DEPTH)
    ) ring (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (io_redirect),
        .enq_i      (accept),
        .enqPc_i    (io_pc),
        .fill_i     (fill),
        .fillData_i (io_imem_resp_data),
        .deq_i      (dequeue),
        .count_o    (count),
        .unfilled_o (unfilled),
        .head_o     (headEntry)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue. The bench plays the PC register and the
// instruction memory; expected fetch addresses and decode handoffs are queued
// by the stimulus and checked by the tick task and a separate decode monitor.
// The queue is built with four entries so that a redirect can find two
// unfilled entries and still accept a third request in the same cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int TB_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } expInst_t;

    logic        clock;
    logic        reset;
    logic [31:0] io_pc;
    logic        io_redirect;
    logic        io_stall;
    logic        io_imem_req_valid;
    logic        io_imem_req_ready;
    logic [31:0] io_imem_req_addr;
    logic        io_imem_resp_valid;
    logic [31:0] io_imem_resp_data;
    logic        io_inst_valid;
    logic        io_inst_ready;
    logic [31:0] io_inst_data;
    logic [31:0] io_inst_pc;

    int          nTests;
    int          nFail;
    int          acceptCount;
    logic        memEnable;
    logic [31:0] redirectTarget;
    logic [31:0] memQ[$];
    logic [31:0] expAddrQ[$];
    expInst_t    expQ[$];

    fetch_queue #(
        .DEPTH (TB_DEPTH)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .io_pc              (io_pc),
        .io_redirect        (io_redirect),
        .io_stall           (io_stall),
        .io_imem_req_valid  (io_imem_req_valid),
        .io_imem_req_ready  (io_imem_req_ready),
        .io_imem_req_addr   (io_imem_req_addr),
        .io_imem_resp_valid (io_imem_resp_valid),
        .io_imem_resp_data  (io_imem_resp_data),
        .io_inst_valid      (io_inst_valid),
        .io_inst_ready      (io_inst_ready),
        .io_inst_data       (io_inst_data),
        .io_inst_pc         (io_inst_pc)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: each word is its address tagged with 0xC0DE in the top half.
    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic reqReady, input logic instReady,
                                 input logic redirect, input logic [31:0] target);
        io_imem_req_ready = reqReady;
        io_inst_ready     = instReady;
        io_redirect       = redirect;
        redirectTarget    = target;
    endtask

    // One clock cycle: sample the request handshake mid-cycle, then after the
    // edge advance the PC register model and the one-cycle-latency memory.
    task automatic tick();
        logic        acc;
        logic [31:0] addr;
        logic [31:0] want;
        @(negedge clock);
        acc  = io_imem_req_valid && io_imem_req_ready;
        addr = io_imem_req_addr;
        if (acc) begin
            if (expAddrQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL req_addr: unexpected fetch of 0x%08h", addr);
            end else begin
                want = expAddrQ.pop_front();
                checkOutput("req_addr", addr, want);
            end
        end
        @(posedge clock);
        #1;
        if (reset) begin
            io_pc = 32'h0;
            memQ.delete();
            io_imem_resp_valid = 1'b0;
        end else begin
            if (io_redirect) begin
                io_pc = redirectTarget;
            end else if (acc) begin
                io_pc = io_pc + 32'd4;
            end
            if (acc) begin
                memQ.push_back(addr);
                acceptCount++;
            end
            if (memEnable && memQ.size() > 0) begin
                io_imem_resp_valid = 1'b1;
                io_imem_resp_data  = memData(memQ.pop_front());
            end else begin
                io_imem_resp_valid = 1'b0;
            end
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Hold req_ready until n more fetches have been accepted.
    task automatic fetchN(input int n);
        int start;
        bit done;
        start = acceptCount;
        done  = 1'b0;
        io_imem_req_ready = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (acceptCount - start >= n) done = 1'b1;
        end
        io_imem_req_ready = 1'b0;
        nTests++;
        if (!done) begin
            nFail++;
            $display("[TB] FAIL fetchN: got %0d accepts, expected %0d", acceptCount - start, n);
        end
    endtask

    // Wait for every queued decode handoff to be seen by the monitor.
    task automatic drain();
        for (int c = 0; c < 40 && expQ.size() != 0; c++) begin
            tick();
        end
        checkOutput("drain_pending", 32'(expQ.size()), 32'd0);
    endtask

    // Decode monitor: every handoff must match the oldest expected instruction.
    always @(negedge clock) begin
        expInst_t e;
        if (io_inst_valid && io_inst_ready) begin
            if (expQ.size() == 0) begin
                nTests++;
                nFail++;
                $display("[TB] FAIL inst_unexpected: got pc 0x%08h data 0x%08h, expected none",
                         io_inst_pc, io_inst_data);
            end else begin
                e = expQ.pop_front();
                checkOutput("inst_pc", io_inst_pc, e.pc);
                checkOutput("inst_data", io_inst_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nTests = 0;
        nFail = 0;
        acceptCount = 0;
        memEnable = 1'b1;
        io_pc = 32'h0;
        io_imem_resp_valid = 1'b0;
        io_imem_resp_data = 32'h0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        resetDut();
        reset = 1'b1;
        #1;
        checkOutput("rst_req_valid", 32'(io_imem_req_valid), 32'd0);
        checkOutput("rst_stall", 32'(io_stall), 32'd1);
        checkOutput("rst_inst_valid", 32'(io_inst_valid), 32'd0);
        resetDut();
        checkOutput("rst_count", 32'(dut.count), 32'd0);
        checkOutput("rst_drop", 32'(dut.dropCnt_q), 32'd0);

        // Back-to-back fetch with one-cycle memory, delivered in order
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4); expAddrQ.push_back(32'h8);
        expQ.push_back('{pc: 32'h0, data: 32'hC0DE_0000});
        expQ.push_back('{pc: 32'h4, data: 32'hC0DE_0004});
        expQ.push_back('{pc: 32'h8, data: 32'hC0DE_0008});
        fetchN(3);
        drain();

        // Decode blocked: queue fills, fetch stops and the PC holds
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4);
        expAddrQ.push_back(32'h8); expAddrQ.push_back(32'hC);
        repeat (8) tick();
        checkOutput("full_count", 32'(dut.count), 32'd4);
        checkOutput("full_req_valid", 32'(io_imem_req_valid), 32'd0);
        checkOutput("full_stall", 32'(io_stall), 32'd1);
        checkOutput("full_pc_hold", io_imem_req_addr, 32'h10);
        tick();
        checkOutput("full_pc_hold2", io_imem_req_addr, 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expQ.push_back('{pc: 32'h0, data: 32'hC0DE_0000});
        expQ.push_back('{pc: 32'h4, data: 32'hC0DE_0004});
        expQ.push_back('{pc: 32'h8, data: 32'hC0DE_0008});
        expQ.push_back('{pc: 32'hC, data: 32'hC0DE_000C});
        drain();

        // Memory not ready for 5 cycles: stall, PC constant, nothing allocated
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("nordy_stall", 32'(io_stall), 32'd1);
            checkOutput("nordy_pc", io_imem_req_addr, 32'h10);
            checkOutput("nordy_count", 32'(dut.count), 32'd0);
        end

        // Reset with two filled entries
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        expAddrQ.push_back(32'h10); expAddrQ.push_back(32'h14);
        fetchN(2);
        tick();
        tick();
        checkOutput("pre_rst_count", 32'(dut.count), 32'd2);
        checkOutput("pre_rst_inst_valid", 32'(io_inst_valid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("in_rst_req_valid", 32'(io_imem_req_valid), 32'd0);
        checkOutput("in_rst_stall", 32'(io_stall), 32'd1);
        checkOutput("in_rst_inst_valid", 32'(io_inst_valid), 32'd0);
        tick();
        checkOutput("in_rst_count", 32'(dut.count), 32'd0);
        checkOutput("in_rst_req_valid2", 32'(io_imem_req_valid), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_count", 32'(dut.count), 32'd0);
        checkOutput("post_rst_inst_valid", 32'(io_inst_valid), 32'd0);

        // Redirect with two unfilled entries plus an accept: three stale responses
        memEnable = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expAddrQ.push_back(32'h0); expAddrQ.push_back(32'h4);
        fetchN(2);
        expAddrQ.push_back(32'h8);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_drop", 32'(dut.dropCnt_q), 32'd3);
        checkOutput("redir_count", 32'(dut.count), 32'd0);
        checkOutput("redir_req_valid", 32'(io_imem_req_valid), 32'd0);
        checkOutput("redir_inst_valid", 32'(io_inst_valid), 32'd0);
        memEnable = 1'b1;
        for (int c = 0; c < 10 && dut.dropCnt_q != 0; c++) tick();
        checkOutput("redir_drop_drained", 32'(dut.dropCnt_q), 32'd0);
        checkOutput("redir_discarded_count", 32'(dut.count), 32'd0);
        checkOutput("redir_new_addr", io_imem_req_addr, 32'h100);
        expAddrQ.push_back(32'h100);
        expQ.push_back('{pc: 32'h100, data: 32'hC0DE_0100});
        fetchN(1);
        drain();

        // Redirect coinciding with a response, one unfilled entry, no accept
        resetDut();
        memEnable = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        expAddrQ.push_back(32'h0);
        fetchN(1);
        memEnable = 1'b1;
        tick();
        checkOutput("coinc_resp_valid", 32'(io_imem_resp_valid), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("coinc_drop", 32'(dut.dropCnt_q), 32'd0);
        checkOutput("coinc_count", 32'(dut.count), 32'd0);
        checkOutput("coinc_req_valid", 32'(io_imem_req_valid), 32'd1);
        checkOutput("coinc_req_addr", io_imem_req_addr, 32'h100);
        expAddrQ.push_back(32'h100);
        expQ.push_back('{pc: 32'h100, data: 32'hC0DE_0100});
        fetchN(1);
        drain();

        checkOutput("addr_pending", 32'(expAddrQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2, sets the number of in-order fetch entries (power of two, at least 2).
REQ-002 Port clock, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, is a synchronous active-high reset.
REQ-004 Port io_pc, input, 32, is the current fetch PC from the PC register.
REQ-005 Port io_redirect, input, 1, is high in the cycle the PC register loads a new PC (flush).
REQ-006 Port io_stall, output, 1, drives the PC register hold control: high means the PC must not advance.
REQ-007 Ports io_imem_req_valid (out, 1), io_imem_req_ready (in, 1) and io_imem_req_addr (out, 32) form the instruction memory request channel.
REQ-008 Ports io_imem_resp_valid (in, 1) and io_imem_resp_data (in, 32) form the response channel: one in-order response per accepted request, at least 1 cycle after acceptance, with no backpressure.
REQ-009 Ports io_inst_valid (out, 1), io_inst_ready (in, 1), io_inst_data (out, 32) and io_inst_pc (out, 32) form the decode-side channel.

Function
REQ-010 Each entry holds pc[31:0], data[31:0] and filled; head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-011 io_imem_req_valid = (count < DEPTH) && (drop_cnt == 0) && !reset; io_imem_req_addr = io_pc.
REQ-012 An accept (req_valid && req_ready) allocates the tail entry with pc = io_pc and filled = 0.
REQ-013 io_stall = !(io_imem_req_valid && io_imem_req_ready); the PC advances by 4 only on an accept cycle.
REQ-014 A response with drop_cnt == 0 writes data into the oldest unfilled entry and sets filled; it is never written to a filled entry.
REQ-015 A response with drop_cnt != 0 is discarded and decrements drop_cnt.
REQ-016 io_inst_valid = head entry allocated && filled; io_inst_data and io_inst_pc come from the head entry; a response reaches decode no earlier than 1 cycle after it arrives.
REQ-017 A dequeue (inst_valid && inst_ready) frees the head entry; enqueue and dequeue in the same cycle leave count unchanged.
REQ-018 Redirect has priority over all other events: all entries are cleared (count = 0, head = tail = 0) and inst_valid is low the next cycle.
REQ-019 On redirect, drop_cnt_next = drop_cnt + (allocated unfilled entries) + (accept this cycle ? 1 : 0) - (resp_valid this cycle ? 1 : 0); the request accepted in the redirect cycle is stale.
REQ-020 A dequeue in the redirect cycle is still a valid handoff to decode.
REQ-021 drop_cnt never exceeds DEPTH; its width is log2(DEPTH)+1 bits.

Reset
REQ-022 While reset is high, the next edge sets count = 0, head = tail = 0, drop_cnt = 0 and all filled = 0.
REQ-023 During reset, io_imem_req_valid = 0, io_inst_valid = 0 and io_stall = 1.
REQ-024 Responses arriving after reset for requests issued before reset are outside the contract; the memory is reset on the same signal.

Structure
REQ-025 A shared package holds DEPTH_DEFAULT = 2, XLEN = 32 and the entry record typedef (pc, data, filled).
REQ-026 One sub-module, fetch_ring, holds the entry storage, pointers and count; fetch_queue holds drop_cnt, the handshake logic and the stall logic.

Verification
REQ-027 Reset then req_ready = 1 with 1-cycle response latency -> addresses 0x0, 0x4, 0x8 issued back-to-back; decode receives (pc 0x0, data D0), (0x4, D1), ... in order.
REQ-028 inst_ready = 0 -> after 2 accepts, count = 2, req_valid = 0 and stall = 1; PC holds at 0x8 until the first dequeue.
REQ-029 Redirect to 0x100 with 2 unfilled entries and an accept in the same cycle -> drop_cnt = 3; the next 3 responses are discarded; the first instruction delivered has pc 0x100.
REQ-030 Redirect coinciding with a response and 1 unfilled entry, no accept -> drop_cnt = 0, and the fetch of 0x100 is issued the next cycle.
REQ-031 req_ready = 0 for 5 cycles -> stall = 1 throughout, the PC stays constant and no entry is allocated.
REQ-032 Reset asserted with count = 2 -> count = 0 and inst_valid = 0 on the next edge, and req_valid = 0 while reset is high.
